// File: rtl/expr_ctrl.sv
// expr_ctrl -- streaming single-digit expression evaluator.
//
// Consumes ASCII characters of the form digit (op digit)* '=' where op is
// '+' or '*', and produces the 16-bit unsigned result (modulo 2^16) when
// the '=' is accepted. A grammar violation parks the block in an error
// state until clr.
//
// Build option:
//   EXPR_PREC_EN  defined   -> '*' binds tighter than '+' (sum/term registers)
//                 undefined -> strict left-to-right evaluation (one accumulator)
//
// Ports:
//   clk        in   1   rising-edge clock
//   clr        in   1   asynchronous active-high reset
//   in         in   8   ASCII character ('0'-'9', '+', '*', '=')
//   in_valid   in   1   in is presented this cycle
//   in_ready   out  1   character accepted when in_valid & in_ready
//   res        out  16  result of the last completed expression
//   res_valid  out  1   one-cycle pulse when res is updated
//   err        out  1   sticky grammar error flag
//   busy       out  1   an expression is partially received
module expr_ctrl (
  input  logic        clk,
  input  logic        clr,
  input  logic [7:0]  in,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] res,
  output logic        res_valid,
  output logic        err,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_DIG = 2'd0,
    S_OP  = 2'd1,
    S_ERR = 2'd2
  } state_t;

  state_t state, state_nx;

  // Character decode. For '0'..'9' the low nibble is the digit value.
  logic       is_digit, is_add, is_mul, is_eq;
  logic [3:0] digit;

  assign is_digit = (in >= 8'h30) && (in <= 8'h39);
  assign is_add   = (in == 8'h2B);
  assign is_mul   = (in == 8'h2A);
  assign is_eq    = (in == 8'h3D);
  assign digit    = in[3:0];

  logic xfer;
  assign xfer = in_valid & in_ready;

  // Datapath events, one per accepted character class.
  logic dig_ev, op_ev, eq_ev, err_ev;
  assign dig_ev = xfer && (state == S_DIG) && is_digit;
  assign op_ev  = xfer && (state == S_OP) && (is_add || is_mul);
  assign eq_ev  = xfer && (state == S_OP) && is_eq;
  assign err_ev = xfer && (state_nx == S_ERR);

  // State register
  always_ff @(posedge clk or posedge clr) begin
    if (clr) state <= S_DIG;
    else     state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    if (xfer) begin
      case (state)
        S_DIG:   state_nx = is_digit ? S_OP : S_ERR;
        S_OP:    state_nx = (is_add || is_mul || is_eq) ? S_DIG : S_ERR;
        default: state_nx = S_ERR;
      endcase
    end
  end

  // Output logic
  always_comb begin
    in_ready = (state != S_ERR);
    err      = (state == S_ERR);
  end

  // Arithmetic. final_val is the value that '=' publishes.
  logic        mul_pend;
  logic [15:0] final_val;

`ifdef EXPR_PREC_EN
  // sum holds the completed '+' terms; term holds the running product.
  logic [15:0] sum, term, term_prod;
  assign term_prod = term * {12'd0, digit};
  assign final_val = sum + term;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      sum      <= 16'd0;
      term     <= 16'd0;
      mul_pend <= 1'b0;
    end else if (dig_ev) begin
      term <= mul_pend ? term_prod : {12'd0, digit};
    end else if (op_ev) begin
      if (is_add) begin
        sum      <= sum + term;
        mul_pend <= 1'b0;
      end else begin
        mul_pend <= 1'b1;
      end
    end else if (eq_ev) begin
      sum      <= 16'd0;
      term     <= 16'd0;
      mul_pend <= 1'b0;
    end
  end
`else
  // Left-to-right: acc starts at 0 with a pending '+', so the first digit
  // simply loads.
  logic [15:0] acc, acc_prod;
  assign acc_prod  = acc * {12'd0, digit};
  assign final_val = acc;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      acc      <= 16'd0;
      mul_pend <= 1'b0;
    end else if (dig_ev) begin
      acc <= mul_pend ? acc_prod : (acc + {12'd0, digit});
    end else if (op_ev) begin
      mul_pend <= is_mul;
    end else if (eq_ev) begin
      acc      <= 16'd0;
      mul_pend <= 1'b0;
    end
  end
`endif

  // Result, completion pulse and busy flag. Errors never touch res.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      res       <= 16'd0;
      res_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      res_valid <= eq_ev;
      if (eq_ev) res <= final_val;
      if (dig_ev)               busy <= 1'b1;
      else if (eq_ev || err_ev) busy <= 1'b0;
    end
  end

endmodule

// File: tb/tb_expr_ctrl.sv
// Self-checking bench for expr_ctrl: directed character strings with
// hand-computed results. Inputs change 1 time unit after the rising edge
// and outputs are sampled there too.
module tb_expr_ctrl;

  logic        clk;
  logic        clr;
  logic [7:0]  in;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] res;
  logic        res_valid;
  logic        err;
  logic        busy;

  int errors = 0;
  int checks = 0;
  int pulses = 0;

  expr_ctrl dut (
    .clk      (clk),
    .clr      (clr),
    .in       (in),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .res      (res),
    .res_valid(res_valid),
    .err      (err),
    .busy     (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count res_valid high cycles; a stretched pulse counts more than once.
  always @(negedge clk) begin
    if (res_valid) pulses <= pulses + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present each character of s, with 0..maxgap idle cycles before each.
  task automatic feed(input string s, input int maxgap);
    int gap;
    for (int i = 0; i < s.len(); i++) begin
      gap = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
      in_valid = 1'b0;
      repeat (gap) step();
      in       = s[i];
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    step();
    clr = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    clr = 1'b1; in = 8'h00; in_valid = 1'b0;
    #3;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (res !== 16'd0) begin errors++; $display("FAIL reset_res got=%0d exp=0", res); end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid got=%b exp=0", res_valid); end
    step();
    clr = 1'b0;
    step();
    $display("reset: done");
  endtask

  task automatic test_precedence();
    int p0;
    logic [15:0] exp_res;
`ifdef EXPR_PREC_EN
    exp_res = 16'd7;
`else
    exp_res = 16'd9;
`endif
    p0 = pulses;
    feed("1+2*3=", 0);
    checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL prec_res_valid got=%b exp=1", res_valid); end
    checks++; if (res !== exp_res) begin errors++; $display("FAIL prec_res got=%0d exp=%0d", res, exp_res); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL prec_err got=%b exp=0", err); end
    step();
    checks++; if (pulses - p0 !== 1) begin errors++; $display("FAIL prec_pulses got=%0d exp=1", pulses - p0); end
    $display("1+2*3= -> res=%0d", res);
  endtask

  task automatic test_overflow();
    feed("9*9*9*9*9*9=", 0);
    checks++; if (res !== 16'd7153) begin errors++; $display("FAIL overflow_res got=%0d exp=7153", res); end
    step();
    $display("9*9*9*9*9*9= -> res=%0d", res);
  endtask

  task automatic test_error();
    int p0;
    p0 = pulses;
    feed("1++", 0);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL error_err got=%b exp=1", err); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL error_in_ready got=%b exp=0", in_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL error_busy got=%b exp=0", busy); end
    checks++; if (res !== 16'd7153) begin errors++; $display("FAIL error_res_kept got=%0d exp=7153", res); end
    // Characters offered while in the error state are not taken.
    feed("5=", 0);
    step();
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL error_sticky got=%b exp=1", err); end
    checks++; if (pulses - p0 !== 0) begin errors++; $display("FAIL error_no_pulse got=%0d exp=0", pulses - p0); end
    // clr acts immediately, before any clock edge.
    clr = 1'b1;
    #2;
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL clr_err got=%b exp=0", err); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL clr_in_ready got=%b exp=1", in_ready); end
    checks++; if (res !== 16'd0) begin errors++; $display("FAIL clr_res got=%0d exp=0", res); end
    step();
    clr = 1'b0;
    feed("4=", 0);
    checks++; if (res !== 16'd4) begin errors++; $display("FAIL after_clr_res got=%0d exp=4", res); end
    step();
    $display("1++ -> err, clr, 4= -> res=%0d", res);
  endtask

  task automatic test_clr_mid();
    int p0;
    p0 = pulses;
    feed("3*", 0);
    // A character offered during clr must be ignored.
    clr = 1'b1; in = "5"; in_valid = 1'b1;
    step();
    clr = 1'b0; in_valid = 1'b0;
    step();
    checks++; if (pulses - p0 !== 0) begin errors++; $display("FAIL clr_mid_no_pulse got=%0d exp=0", pulses - p0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL clr_mid_busy got=%b exp=0", busy); end
    feed("2+1=", 0);
    checks++; if (res !== 16'd3) begin errors++; $display("FAIL clr_mid_res got=%0d exp=3", res); end
    step();
    step();
    checks++; if (pulses - p0 !== 1) begin errors++; $display("FAIL clr_mid_pulses got=%0d exp=1", pulses - p0); end
    $display("3* clr 2+1= -> res=%0d", res);
  endtask

  task automatic test_stall();
    string s;
    int gap;
    logic started;
    s = "8*2=";
    started = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stall_busy_idle got=%b exp=0", busy); end
    for (int i = 0; i < s.len(); i++) begin
      gap = int'($urandom_range(3, 0));
      in_valid = 1'b0;
      for (int g = 0; g < gap; g++) begin
        step();
        if (started) begin
          checks++; if (busy !== 1'b1) begin errors++; $display("FAIL stall_busy_gap got=%b exp=1", busy); end
        end
      end
      in = s[i]; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      started = 1'b1;
      if (i < s.len() - 1) begin
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL stall_busy_mid got=%b exp=1", busy); end
      end else begin
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stall_busy_end got=%b exp=0", busy); end
        checks++; if (res !== 16'd16) begin errors++; $display("FAIL stall_res got=%0d exp=16", res); end
      end
    end
    step();
    $display("8*2= with gaps -> res=%0d", res);
  endtask

  task automatic test_back_to_back();
    int p0;
    p0 = pulses;
    in_valid = 1'b1;
    in = "1"; step();
    in = "="; step();
    checks++; if (res_valid !== 1'b1 || res !== 16'd1) begin errors++; $display("FAIL b2b_first got=%b/%0d exp=1/1", res_valid, res); end
    in = "2"; step();
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL b2b_pulse_width got=%b exp=0", res_valid); end
    in = "="; step();
    checks++; if (res_valid !== 1'b1 || res !== 16'd2) begin errors++; $display("FAIL b2b_second got=%b/%0d exp=1/2", res_valid, res); end
    in_valid = 1'b0;
    step();
    checks++; if (res_valid !== 1'b0 || res !== 16'd2) begin errors++; $display("FAIL b2b_hold got=%b/%0d exp=0/2", res_valid, res); end
    step();
    checks++; if (pulses - p0 !== 2) begin errors++; $display("FAIL b2b_pulses got=%0d exp=2", pulses - p0); end
    $display("1=2= -> pulses=%0d res=%0d", pulses - p0, res);
  endtask

  initial begin
    test_reset();
    test_precedence();
    test_overflow();
    test_error();
    test_clr_mid();
    test_stall();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
